// File: rtl/vga_pkg.sv
// Shared VGA constants: screen sizes, coordinate widths, mode codes.
// Also used by anything driving a vga_adapter.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_FILL    = 2'b00,
    MODE_OUTLINE = 2'b01,
    MODE_CLEAR   = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRAW   = 2'd1,
    S_FINISH = 2'd2
  } state_e;

  localparam logic [55:0] RES_640 = "640x480";
  localparam logic [55:0] RES_320 = "320x240";
  localparam logic [55:0] RES_160 = "160x120";

  function automatic int res_xmax(
    input logic [55:0] res
  );
    int v;
    case (res)
      RES_160: v = 160;
      RES_320: v = 320;
      default: v = 640;
    endcase
    return v;
  endfunction

  function automatic int res_ymax(
    input logic [55:0] res
  );
    int v;
    case (res)
      RES_160: v = 120;
      RES_320: v = 240;
      default: v = 480;
    endcase
    return v;
  endfunction

  function automatic int res_xbits(
    input logic [55:0] res
  );
    int v;
    case (res)
      RES_160: v = 8;
      RES_320: v = 9;
      default: v = 10;
    endcase
    return v;
  endfunction

  function automatic int res_ybits(
    input logic [55:0] res
  );
    int v;
    case (res)
      RES_160: v = 7;
      RES_320: v = 8;
      default: v = 9;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vga_rect_drawer_if.sv
// Pixel-write bus toward vga_adapter: x, y, color, write.
// master = drawer side, slave = adapter/monitor side.
interface vga_rect_drawer_if #(
  parameter int NX = 10,
  parameter int NY = 9,
  parameter int CD = 9
);
  logic [NX-1:0] x;
  logic [NY-1:0] y;
  logic [CD-1:0] color;
  logic          write;

  modport master (
    output x, y, color, write
  );

  modport slave (
    input x, y, color, write
  );
endinterface

// File: rtl/vga_scan_counter.sv
// Row-major x/y scan counter with clipped end bounds.
// Ports: load/ld_x/ld_y start a scan, step advances, xs/xe/ye bounds,
// x/y current position, nx/ny next position, last = final position.
module vga_scan_counter #(
  parameter int nX = 10,
  parameter int nY = 9
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          step,
  input  logic [nX-1:0] ld_x,
  input  logic [nY-1:0] ld_y,
  input  logic [nX-1:0] xs,
  input  logic [nX:0]   xe,
  input  logic [nY:0]   ye,
  output logic [nX-1:0] x,
  output logic [nY-1:0] y,
  output logic [nX-1:0] nx,
  output logic [nY-1:0] ny,
  output logic          last
);

  logic wrap_x;
  logic wrap_y;

  // ends are exclusive, compared one bit wider so x0+w never wraps
  assign wrap_x = ({1'b0, x} + 1'b1) >= xe;
  assign wrap_y = ({1'b0, y} + 1'b1) >= ye;
  assign last   = wrap_x && wrap_y;

  always_comb begin
    nx = x;
    ny = y;
    if (load) begin
      nx = ld_x;
      ny = ld_y;
    end else if (step) begin
      if (wrap_x) begin
        nx = xs;
        ny = y + 1'b1;
      end else begin
        nx = x + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else begin
      x <= nx;
      y <= ny;
    end
  end

endmodule

// File: rtl/vga_rect_drawer.sv
// Rectangle fill/outline/clear engine writing one pixel per cycle.
// Ports: CLOCK_50, resetn, start/mode/x0/y0/w/h/col_in job request,
// pix pixel-write bus (x, y, color, write), busy, done.
module vga_rect_drawer
  import vga_pkg::*;
#(
  parameter logic [55:0] RESOLUTION  = "640x480",
  parameter int          COLOR_DEPTH = 9,
  parameter int          nX = res_xbits(RESOLUTION),
  parameter int          nY = res_ybits(RESOLUTION)
)(
  input  logic                   CLOCK_50,
  input  logic                   resetn,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [nX-1:0]          x0,
  input  logic [nY-1:0]          y0,
  input  logic [nX-1:0]          w,
  input  logic [nY-1:0]          h,
  input  logic [COLOR_DEPTH-1:0] col_in,
  vga_rect_drawer_if.master      pix,
  output logic                   busy,
  output logic                   done
);

  localparam int XMAX = res_xmax(RESOLUTION);
  localparam int YMAX = res_ymax(RESOLUTION);
  localparam logic [nX:0] XM = (nX+1)'(XMAX);
  localparam logic [nY:0] YM = (nY+1)'(YMAX);

  state_e                 state;
  mode_e                  mode_q;
  logic [nX-1:0]          x0_q;
  logic [nY-1:0]          y0_q;
  logic [nX:0]            xe_q;
  logic [nY:0]            ye_q;
  logic [COLOR_DEPTH-1:0] col_q;
  logic                   empty_q;
  logic                   wr;

  logic [nX-1:0] j_x0;
  logic [nY-1:0] j_y0;
  logic [nX:0]   j_xe;
  logic [nY:0]   j_ye;
  logic          j_empty;
  logic [nX:0]   sum_x;
  logic [nY:0]   sum_y;

  logic [nX-1:0] cx;
  logic [nY-1:0] cy;
  logic [nX-1:0] nx;
  logic [nY-1:0] ny;
  logic          scan_last;
  logic          last_pos;
  logic          accept;
  logic          step;
  logic          on_edge;

  assign sum_x = {1'b0, x0} + {1'b0, w};
  assign sum_y = {1'b0, y0} + {1'b0, h};

  // Effective job window; clear overrides the request inputs.
  always_comb begin
    j_x0    = x0;
    j_y0    = y0;
    j_xe    = (sum_x > XM) ? XM : sum_x;
    j_ye    = (sum_y > YM) ? YM : sum_y;
    j_empty = (w == '0) || (h == '0) ||
              ({1'b0, x0} >= XM) ||
              ({1'b0, y0} >= YM);
    if (mode_e'(mode) == MODE_CLEAR) begin
      j_x0    = '0;
      j_y0    = '0;
      j_xe    = XM;
      j_ye    = YM;
      j_empty = 1'b0;
    end
  end

  assign accept   = (state == S_IDLE) && start;
  assign last_pos = empty_q || scan_last;
  assign step     = (state == S_DRAW) && !last_pos;

  vga_scan_counter #(
    .nX (nX),
    .nY (nY)
  ) u_scan (
    .clk   (CLOCK_50),
    .rst_n (resetn),
    .load  (accept),
    .step  (step),
    .ld_x  (j_x0),
    .ld_y  (j_y0),
    .xs    (x0_q),
    .xe    (xe_q),
    .ye    (ye_q),
    .x     (cx),
    .y     (cy),
    .nx    (nx),
    .ny    (ny),
    .last  (scan_last)
  );

  // Border test for the position the counter moves to next.
  assign on_edge = (nx == x0_q) ||
                   ({1'b0, nx} == xe_q - 1'b1) ||
                   (ny == y0_q) ||
                   ({1'b0, ny} == ye_q - 1'b1);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      mode_q  <= MODE_FILL;
      x0_q    <= '0;
      y0_q    <= '0;
      xe_q    <= '0;
      ye_q    <= '0;
      col_q   <= '0;
      empty_q <= 1'b0;
      wr      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          wr   <= 1'b0;
          done <= 1'b0;
          if (start) begin
            mode_q  <= mode_e'(mode);
            x0_q    <= j_x0;
            y0_q    <= j_y0;
            xe_q    <= j_xe;
            ye_q    <= j_ye;
            col_q   <= col_in;
            empty_q <= j_empty;
            // first position is (x0,y0), always on the border
            wr      <= !j_empty;
            busy    <= 1'b1;
            state   <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (last_pos) begin
            wr    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_FINISH;
          end else begin
            wr <= (mode_q != MODE_OUTLINE) || on_edge;
          end
        end
        S_FINISH: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          wr    <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign pix.x     = cx;
  assign pix.y     = cy;
  assign pix.color = col_q;
  assign pix.write = wr;

endmodule

// File: tb/tb_vga_rect_drawer.sv
// Self-checking bench for vga_rect_drawer at 160x120.
// Compares write beats against a rectangle model built from plain loops.
module tb_vga_rect_drawer;
  import vga_pkg::*;

  localparam int XMAX = 160;
  localparam int YMAX = 120;
  localparam int NX   = 8;
  localparam int NY   = 7;
  localparam int CD   = 9;

  logic          clk    = 1'b0;
  logic          resetn = 1'b0;
  logic          start  = 1'b0;
  logic [1:0]    mode   = '0;
  logic [NX-1:0] x0     = '0;
  logic [NY-1:0] y0     = '0;
  logic [NX-1:0] w      = '0;
  logic [NY-1:0] h      = '0;
  logic [CD-1:0] col    = '0;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int k;
    int x;
    int y;
    int c;
  } beat_t;

  vga_rect_drawer_if #(.NX(NX), .NY(NY), .CD(CD)) pix ();

  vga_rect_drawer #(
    .RESOLUTION  ("160x120"),
    .COLOR_DEPTH (CD)
  ) dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .start    (start),
    .mode     (mode),
    .x0       (x0),
    .y0       (y0),
    .w        (w),
    .h        (h),
    .col_in   (col),
    .pix      (pix),
    .busy     (busy),
    .done     (done)
  );

  always #10 clk = ~clk;

  // Caller is at a falling edge; start is raised immediately.
  task automatic run_job(
    input int    m,
    input int    px0,
    input int    py0,
    input int    pw,
    input int    ph,
    input int    pc,
    input bit    disturb,
    input string name
  );
    beat_t expq[$];
    beat_t gotq[$];
    beat_t b;
    int ex0, ey0, xe, ye, idx;
    int exp_done, got_done;
    int oob, busy_bad, diff;
    if (m == 2) begin
      ex0 = 0; ey0 = 0; xe = XMAX; ye = YMAX;
    end else begin
      ex0 = px0; ey0 = py0;
      xe = (px0 + pw > XMAX) ? XMAX : px0 + pw;
      ye = (py0 + ph > YMAX) ? YMAX : py0 + ph;
    end
    idx = 0;
    for (int yy = ey0; yy < ye; yy++) begin
      for (int xx = ex0; xx < xe; xx++) begin
        idx++;
        if (m != 1 || xx == ex0 || xx == xe - 1 ||
            yy == ey0 || yy == ye - 1) begin
          b.k = idx; b.x = xx; b.y = yy; b.c = pc;
          expq.push_back(b);
        end
      end
    end
    exp_done = ((idx == 0) ? 1 : idx) + 1;

    mode  = 2'(m);
    x0    = NX'(px0);
    y0    = NY'(py0);
    w     = NX'(pw);
    h     = NY'(ph);
    col   = CD'(pc);
    start = 1'b1;
    got_done = 0;
    oob = 0;
    busy_bad = 0;
    for (int k = 1; k <= exp_done + 5; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (disturb && k == 2) begin
        start = 1'b1;
        mode  = 2'($urandom_range(0, 3));
        x0    = NX'($urandom);
        y0    = NY'($urandom);
        w     = NX'($urandom);
        h     = NY'($urandom);
        col   = CD'($urandom);
      end
      if (disturb && k == 3) start = 1'b0;
      if (pix.write === 1'b1) begin
        b.k = k;
        b.x = int'(pix.x);
        b.y = int'(pix.y);
        b.c = int'(pix.color);
        gotq.push_back(b);
        if (b.x >= XMAX || b.y >= YMAX) oob++;
      end
      if (done === 1'b1) begin
        if (busy !== 1'b0) busy_bad++;
        got_done = k;
        break;
      end else if (busy !== 1'b1) begin
        busy_bad++;
      end
    end
    start = 1'b0;

    total++;
    if (got_done != exp_done) begin
      bad++;
      $display("FAIL %s done_cycle got=%0d want=%0d",
               name, got_done, exp_done);
    end
    diff = -1;
    if (gotq.size() != expq.size()) begin
      diff = 0;
    end else begin
      for (int i = 0; i < expq.size(); i++) begin
        if (diff < 0 &&
            (gotq[i].k != expq[i].k || gotq[i].x != expq[i].x ||
             gotq[i].y != expq[i].y || gotq[i].c != expq[i].c))
          diff = i;
      end
    end
    total++;
    if (diff >= 0) begin
      bad++;
      $display("FAIL %s beats got_n=%0d want_n=%0d first_bad=%0d",
               name, gotq.size(), expq.size(), diff);
    end
    total++;
    if (oob != 0) begin
      bad++;
      $display("FAIL %s out_of_range got=%0d want=0", name, oob);
    end
    total++;
    if (busy_bad != 0) begin
      bad++;
      $display("FAIL %s busy got_bad=%0d want=0", name, busy_bad);
    end
    if (got_done != 0) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0) begin
        bad++;
        $display("FAIL %s done_width got=%b want=0", name, done);
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (pix.write !== 1'b0) begin
      bad++; $display("FAIL rst_write got=%b want=0", pix.write);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL rst_busy got=%b want=0", busy);
    end
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL rst_done got=%b want=0", done);
    end
    total++;
    if (pix.x !== '0) begin
      bad++; $display("FAIL rst_x got=%0d want=0", pix.x);
    end
    total++;
    if (pix.y !== '0) begin
      bad++; $display("FAIL rst_y got=%0d want=0", pix.y);
    end
    total++;
    if (pix.color !== '0) begin
      bad++; $display("FAIL rst_color got=%0h want=0", pix.color);
    end
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, pix.write} !== 3'b000) begin
      bad++;
      $display("FAIL idle_out got=%b want=000",
               {busy, done, pix.write});
    end
  endtask

  task automatic test_fill();
    run_job(0, 10, 20, 4, 3, 'h1FF, 1'b0, "fill_basic");
  endtask

  task automatic test_outline();
    run_job(1, 0, 0, 4, 4, 'h0A5, 1'b0, "outline");
  endtask

  task automatic test_clip();
    run_job(0, 158, 118, 5, 5, 'h123, 1'b0, "clip_corner");
  endtask

  task automatic test_degenerate();
    run_job(0, 5, 5, 0, 3, 'h011, 1'b0, "w_zero");
    run_job(1, 5, 5, 3, 0, 'h022, 1'b0, "h_zero");
    run_job(0, 200, 5, 4, 4, 'h033, 1'b0, "x0_off");
    run_job(0, 5, 125, 4, 4, 'h044, 1'b0, "y0_off");
  endtask

  task automatic test_ignore_start();
    run_job(0, 20, 30, 6, 3, 'h155, 1'b1, "ignore_start");
    run_job(1, 40, 50, 5, 5, 'h0F0, 1'b1, "ignore_start_ol");
  endtask

  task automatic test_back_to_back();
    run_job(0, 1, 2, 3, 2, 'h101, 1'b0, "b2b_a");
    run_job(1, 7, 8, 3, 3, 'h102, 1'b0, "b2b_b");
    run_job(3, 159, 119, 9, 9, 'h103, 1'b0, "b2b_c");
  endtask

  task automatic test_reset_abort();
    int quiet_bad;
    mode  = 2'd0;
    x0    = NX'(30);
    y0    = NY'(40);
    w     = NX'(5);
    h     = NY'(4);
    col   = CD'(9'h1A5);
    start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    total++;
    if (pix.write !== 1'b1 || pix.x !== NX'(34)) begin
      bad++;
      $display("FAIL abort_pre got=%b/%0d want=1/34",
               pix.write, pix.x);
    end
    #3 resetn = 1'b0;
    #1;
    total++;
    if (pix.write !== 1'b0) begin
      bad++; $display("FAIL abort_write got=%b want=0", pix.write);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL abort_busy got=%b want=0", busy);
    end
    quiet_bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || pix.write !== 1'b0) quiet_bad++;
      if (k == 2) resetn = 1'b1;
    end
    total++;
    if (quiet_bad != 0) begin
      bad++; $display("FAIL abort_quiet got=%0d want=0", quiet_bad);
    end
    run_job(0, 30, 40, 5, 4, 'h0C3, 1'b0, "after_abort");
  endtask

  task automatic test_clear();
    run_job(2, 77, 33, 9, 9, 0, 1'b0, "clear");
  endtask

  task automatic test_random();
    int m, px0, py0, pw, ph, pc;
    for (int i = 0; i < 24; i++) begin
      m   = $urandom_range(0, 3);
      if (m == 2) m = 0;
      px0 = $urandom_range(0, 170);
      py0 = $urandom_range(0, 127);
      if (i % 4 == 0) begin
        pw = $urandom_range(100, 255);
        ph = $urandom_range(0, 4);
      end else begin
        pw = $urandom_range(0, 40);
        ph = $urandom_range(0, 20);
      end
      pc = $urandom_range(0, 511);
      run_job(m, px0, py0, pw, ph, pc, 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_outline();
    test_clip();
    test_degenerate();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_clear();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
